// File: rtl/key_event_encoder.sv
// key_event_encoder: synchronises and debounces 8 push-buttons and turns each
// debounced press into a single one-hot bus write, one at a time, with a fixed
// idle gap between writes.
// Optional macro KEY_RELEASE_EN: also report debounced releases (address 2'b01),
// served only when no press is waiting.

module key_debounce #(
  parameter int DEBOUNCE_CNT = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic level,
  output logic stable,
  output logic rise,
  output logic fall
);
  logic [7:0] cnt;
  logic       flip;

  // this tick completes the run of disagreeing samples
  assign flip = tick && (level != stable) && (cnt == 8'(DEBOUNCE_CNT - 1));
  assign rise = flip && !stable;
  assign fall = flip && stable;

  // count consecutive disagreeing samples; any agreeing sample restarts the run
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (tick) begin
      if (level == stable || flip) cnt <= '0;
      else                         cnt <= cnt + 8'd1;
      if (flip) stable <= ~stable;
    end
  end
endmodule

module key_event_encoder #(
  parameter int SAMPLE_DIV   = 50000,
  parameter int DEBOUNCE_CNT = 10,
  parameter int GAP_CYCLES   = 4,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic       CLOCK50M,
  input  logic       reset,
  input  logic [7:0] raw_keys,
  output logic       write,
  output logic [1:0] address,
  output logic [7:0] user_input,
  output logic [7:0] pending
);
  localparam int DW = $clog2(SAMPLE_DIV);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, EMIT, GAP} state_t;

  logic [7:0]    norm, sync1, sync2, stable, rise, fall;
  logic [DW-1:0] div;
  logic          tick;
  state_t        state, state_nx;
  logic [GW-1:0] gap_cnt, gap_nx;
  logic [7:0]    code_q, code_nx, src, sel, clr_press;

  // pressed = 1 from here on, whatever the button wiring
  assign norm = (ACTIVE_LOW != 0) ? ~raw_keys : raw_keys;

  // two-flop synchroniser; reset holds the released level
  always_ff @(posedge CLOCK50M) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= norm;
      sync2 <= sync1;
    end
  end

  assign tick = (div == DW'(SAMPLE_DIV - 1));

  // sample divider, one-cycle tick at terminal count
  always_ff @(posedge CLOCK50M) begin
    if (reset || tick) div <= '0;
    else               div <= div + DW'(1);
  end

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_key
      key_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_db (
        .clk    (CLOCK50M),
        .reset  (reset),
        .tick   (tick),
        .level  (sync2[gi]),
        .stable (stable[gi]),
        .rise   (rise[gi]),
        .fall   (fall[gi])
      );
    end
  endgenerate

  // pending presses; a new press in the cycle its bit is served keeps it set
  always_ff @(posedge CLOCK50M) begin
    if (reset) pending <= '0;
    else       pending <= (pending & ~clr_press) | rise;
  end

`ifdef KEY_RELEASE_EN
  logic [7:0] release_pending, clr_rel;
  logic [1:0] addr_q, addr_nx;

  // pending releases, same merge and set-wins rules as presses
  always_ff @(posedge CLOCK50M) begin
    if (reset) release_pending <= '0;
    else       release_pending <= (release_pending & ~clr_rel) | fall;
  end

  assign src = (pending != 8'h00) ? pending : release_pending;
`else
  assign src = pending;
`endif

  // isolate lowest set bit: fixed priority, key 0 first
  assign sel = src & 8'(~src + 8'd1);

  // emitter next-state; the IDLE decision cycle is itself the last gap cycle,
  // so the counter covers GAP_CYCLES-1 cycles
  always_comb begin
    state_nx  = state;
    gap_nx    = gap_cnt;
    code_nx   = code_q;
    clr_press = '0;
`ifdef KEY_RELEASE_EN
    clr_rel   = '0;
    addr_nx   = addr_q;
`endif
    case (state)
      IDLE: if (src != 8'h00) begin
        state_nx = EMIT;
        code_nx  = sel;
`ifdef KEY_RELEASE_EN
        if (pending != 8'h00) begin
          clr_press = sel;
          addr_nx   = 2'b00;
        end else begin
          clr_rel = sel;
          addr_nx = 2'b01;
        end
`else
        clr_press = sel;
`endif
      end
      EMIT: begin
        if (GAP_CYCLES > 1) begin
          state_nx = GAP;
          gap_nx   = GW'(GAP_CYCLES - 1);
        end else begin
          state_nx = IDLE;
        end
      end
      GAP: begin
        gap_nx = gap_cnt - GW'(1);
        if (gap_cnt <= GW'(1)) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // emitter state register
  always_ff @(posedge CLOCK50M) begin
    if (reset) begin
      state   <= IDLE;
      gap_cnt <= '0;
      code_q  <= '0;
`ifdef KEY_RELEASE_EN
      addr_q  <= 2'b00;
`endif
    end else begin
      state   <= state_nx;
      gap_cnt <= gap_nx;
      code_q  <= code_nx;
`ifdef KEY_RELEASE_EN
      addr_q  <= addr_nx;
`endif
    end
  end

  assign write      = (state == EMIT);
  assign user_input = write ? code_q : 8'h00;
`ifdef KEY_RELEASE_EN
  assign address    = write ? addr_q : 2'b00;
`else
  assign address    = 2'b00;
`endif
endmodule

// File: tb/tb_key_event_encoder.sv
// Directed bench for key_event_encoder (SAMPLE_DIV=4, DEBOUNCE_CNT=3, GAP_CYCLES=2).
module tb_key_event_encoder;
  localparam int SD = 4, DC = 3, GC = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] raw_keys = 8'hFF;
  logic       write;
  logic [1:0] address;
  logic [7:0] user_input, pending;

  key_event_encoder #(.SAMPLE_DIV(SD), .DEBOUNCE_CNT(DC), .GAP_CYCLES(GC), .ACTIVE_LOW(1)) dut (
    .CLOCK50M   (clk),
    .reset      (reset),
    .raw_keys   (raw_keys),
    .write      (write),
    .address    (address),
    .user_input (user_input),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  typedef struct {logic [7:0] code; logic [1:0] addr; int cyc;} strobe_t;
  typedef struct {logic [7:0] keys; logic [7:0] exp_pend; int n; logic [2:0][7:0] codes;} vec_t;

  strobe_t sq[$];
  vec_t    vt[5];
  int      cyc = 0, nchk = 0, nbad = 0;
  bit      prev_write = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // strobe recorder plus always-on output rules
  always @(negedge clk) begin
    if (reset) prev_write = 1'b0;
    else begin
      if (write) begin
        chk("write_back_to_back", {31'd0, prev_write}, 0);
        sq.push_back('{user_input, address, cyc});
      end else begin
        chk("idle_outputs", {22'd0, address, user_input}, 0);
      end
      prev_write = write;
    end
  end

  task automatic wait_pend(input int bound, output int lat);
    lat = -1;
    for (int i = 1; i <= bound; i++) begin
      @(negedge clk);
      if (pending != 8'h00) begin lat = i; break; end
    end
  endtask

  task automatic wait_q(input int n, input int bound);
    for (int i = 0; i < bound; i++) begin
      if (sq.size() >= n) break;
      @(negedge clk);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    vt[0] = '{8'h04, 8'h04, 1, {8'h00, 8'h00, 8'h04}};
    vt[1] = '{8'h89, 8'h89, 3, {8'h80, 8'h08, 8'h01}};
    vt[2] = '{8'h40, 8'h40, 1, {8'h00, 8'h00, 8'h40}};
    vt[3] = '{8'h81, 8'h81, 2, {8'h00, 8'h80, 8'h01}};
    vt[4] = '{8'h02, 8'h02, 1, {8'h00, 8'h00, 8'h02}};

    // reset state and quiet idle
    repeat (3) @(negedge clk);
    chk("reset_outputs", {21'd0, write, address, user_input}, 0);
    chk("reset_pending", pending, 0);
    reset = 1'b0;
    repeat (50) @(negedge clk);
    chk("idle_no_strobe", sq.size(), 0);
    chk("idle_pending", pending, 0);
    chk("idle_write", write, 0);

    // table: press pattern, expected pending, strobe order and spacing
    foreach (vt[v]) begin
      sq.delete();
      raw_keys = ~vt[v].keys;
      wait_pend(100, lat);
      chk($sformatf("v%0d_pend_seen", v), (lat > 0), 1);
      chk($sformatf("v%0d_pending", v), pending, vt[v].exp_pend);
      @(negedge clk);
      chk($sformatf("v%0d_latency_write", v), write, 1);
      chk($sformatf("v%0d_first_code", v), user_input, vt[v].codes[0]);
      wait_q(vt[v].n, 60);
      chk($sformatf("v%0d_strobe_count", v), sq.size(), vt[v].n);
      for (int k = 0; k < vt[v].n && k < sq.size(); k++) begin
        chk($sformatf("v%0d_code%0d", v, k), sq[k].code, vt[v].codes[k]);
        chk($sformatf("v%0d_addr%0d", v, k), sq[k].addr, 2'b00);
        if (k > 0) chk($sformatf("v%0d_spacing%0d", v, k), sq[k].cyc - sq[k-1].cyc, GC + 1);
      end
      repeat (5) @(negedge clk);
      chk($sformatf("v%0d_pending_drained", v), pending, 0);
      raw_keys = 8'hFF;
      repeat (60) @(negedge clk);
`ifdef KEY_RELEASE_EN
      chk($sformatf("v%0d_total_with_release", v), sq.size(), 2 * vt[v].n);
      for (int k = 0; k < vt[v].n && vt[v].n + k < sq.size(); k++) begin
        chk($sformatf("v%0d_rel_code%0d", v, k), sq[vt[v].n + k].code, vt[v].codes[k]);
        chk($sformatf("v%0d_rel_addr%0d", v, k), sq[vt[v].n + k].addr, 2'b01);
        if (k > 0) chk($sformatf("v%0d_rel_spacing%0d", v, k),
                       sq[vt[v].n + k].cyc - sq[vt[v].n + k - 1].cyc, GC + 1);
      end
`else
      chk($sformatf("v%0d_no_release_strobe", v), sq.size(), vt[v].n);
`endif
    end

    // short glitch on key 5 spanning one tick
    sq.delete();
    raw_keys = 8'hDF;
    repeat (5) @(negedge clk);
    raw_keys = 8'hFF;
    repeat (40) @(negedge clk);
    chk("glitch_no_strobe", sq.size(), 0);
    chk("glitch_pending", pending, 0);

    // two disagreeing ticks, two agreeing, two disagreeing: count restarts
    raw_keys = 8'hDF; repeat (8) @(negedge clk);
    raw_keys = 8'hFF; repeat (8) @(negedge clk);
    raw_keys = 8'hDF; repeat (8) @(negedge clk);
    raw_keys = 8'hFF; repeat (40) @(negedge clk);
    chk("restart_no_strobe", sq.size(), 0);

    // reset during a GAP with 8'h88 still pending
    sq.delete();
    raw_keys = ~8'h89;
    wait_pend(100, lat);
    chk("rst_pend_89", pending, 8'h89);
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      if (write) begin lat = i; break; end
      @(negedge clk);
    end
    chk("rst_first_strobe_seen", (lat >= 0), 1);
    chk("rst_first_code", user_input, 8'h01);
    chk("rst_pend_88", pending, 8'h88);
    @(negedge clk);
    chk("rst_in_gap", write, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_outputs", {21'd0, write, address, user_input}, 0);
    chk("rst_mid_pending", pending, 0);
    @(negedge clk);
    reset = 1'b0;
    sq.delete();
    wait_pend(100, lat);
    chk("rst_refresh_latency", lat, 12);
    chk("rst_refresh_pending", pending, 8'h89);
    wait_q(3, 60);
    chk("rst_refresh_count", sq.size(), 3);
    if (sq.size() >= 3) begin
      chk("rst_refresh_c0", sq[0].code, 8'h01);
      chk("rst_refresh_c1", sq[1].code, 8'h08);
      chk("rst_refresh_c2", sq[2].code, 8'h80);
    end
    raw_keys = 8'hFF;
    repeat (60) @(negedge clk);

    $display("test done: total=%0d bad=%0d", nchk, nbad);
    $finish;
  end
endmodule
